// File: rtl/pipe_pkg.sv
// Shared types and helpers for the round-robin pipe arbiter.
package pipe_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    // Next round-robin index after idx, wrapping at n-1 back to 0.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after start, with wrap-around.
module rr_pick
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    start,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any_req
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any_req  = 1'b0;
        idx      = start;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!any_req && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                any_req    = 1'b1;
            end
            idx = ID_W'(rr_next(32'(idx), NUM_REQ));
        end
    end

endmodule

// File: rtl/pipe_rr_arbiter.sv
// Round-robin N:1 arbiter feeding a registered pipe enqueue port.
// Define PIPE_RR_ARBITER_LOCK_EN to hold the grant for a whole burst (until req_last).
module pipe_rr_arbiter
    import pipe_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned DATA_SIZE = 32,
    localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_SIZE-1:0]         out_data,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [ID_W-1:0]              out_id,
    input  logic                         out_ready,
    output logic                         locked
);

    logic                 load_en;
    logic                 xfer;
    logic                 any_req;
    logic                 ptr_adv;
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      grant_id;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [DATA_SIZE-1:0] data_arr [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_SIZE +: DATA_SIZE];
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req      (eligible),
        .start    (rr_ptr_q),
        .grant    (grant),
        .grant_id (grant_id),
        .any_req  (any_req)
    );

    assign load_en = !out_valid || out_ready;
    // Gated by rst_n so nothing is accepted while the register is being cleared.
    assign req_ready = (rst_n && load_en && any_req) ? grant : '0;
    assign xfer      = |(req_valid & req_ready);
    assign rr_ptr_d  = ptr_adv ? ID_W'(rr_next(32'(grant_id), NUM_REQ)) : rr_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_id    <= '0;
            rr_ptr_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= data_arr[grant_id];
                out_last  <= req_last[grant_id];
                out_id    <= grant_id;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef PIPE_RR_ARBITER_LOCK_EN
    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        case (state_q)
            ARB_IDLE: begin
                if (xfer && !req_last[grant_id]) begin
                    state_d   = ARB_LOCKED;
                    lock_id_d = grant_id;
                end
            end
            ARB_LOCKED: begin
                if (xfer && req_last[grant_id]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // While locked, the owner is the only candidate even when it is idle.
    always_comb begin
        locked   = (state_q == ARB_LOCKED);
        eligible = req_valid;
        if (locked) begin
            eligible = req_valid & (NUM_REQ'(1) << lock_id_q);
        end
        ptr_adv = xfer && req_last[grant_id];
    end
`else
    assign locked   = 1'b0;
    assign eligible = req_valid;
    assign ptr_adv  = xfer;
`endif

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Self-checking bench for pipe_rr_arbiter: reset, vector table, hand sequences, random vs model.
module tb_pipe_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid, out_last, out_ready, locked;
    logic [1:0]      out_id;

    logic [DW-1:0]   dat [N];

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic          m_valid, m_last, m_locked;
    logic [DW-1:0] m_data;
    int            m_id, m_ptr, m_lock_id;

    typedef struct {
        logic [3:0] v;
        logic       r;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] id;
    } vec_t;

    vec_t tbl [14];

    pipe_rr_arbiter #(
        .NUM_REQ   (N),
        .DATA_SIZE (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_id    (out_id),
        .out_ready (out_ready),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dat[i];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_last = 1'b0; m_data = '0; m_id = 0;
        m_ptr = 0; m_locked = 1'b0; m_lock_id = 0;
    endtask

    // First eligible valid requester scanning upward from the pointer; -1 if none.
    function automatic int model_grant(input logic [N-1:0] v);
        int best = -1;
        for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (best < 0 && v[idx] && (!m_locked || idx == m_lock_id)) best = idx;
        end
        return best;
    endfunction

    function automatic logic [N-1:0] model_ready(input int g);
        logic [N-1:0] r = '0;
        if (g >= 0 && (!m_valid || out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_clock(input int g);
        if (g >= 0 && (!m_valid || out_ready)) begin
            m_valid = 1'b1;
            m_data  = dat[g];
            m_last  = req_last[g];
            m_id    = g;
`ifdef PIPE_RR_ARBITER_LOCK_EN
            if (!m_locked && !req_last[g]) begin
                m_locked  = 1'b1;
                m_lock_id = g;
            end else if (m_locked && req_last[g]) begin
                m_locked = 1'b0;
            end
            if (req_last[g]) m_ptr = (g + 1) % N;
`else
            m_ptr = (g + 1) % N;
`endif
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r);
        @(negedge clk);
        req_valid = v;
        req_last  = l;
        out_ready = r;
    endtask

    // One clock checked against the model; xg is the transferred requester or -1.
    task automatic step_model(input string tag, output int xg);
        int g;
        #1;
        g  = model_grant(req_valid);
        xg = (g >= 0 && (!m_valid || out_ready)) ? g : -1;
        check({tag, " req_ready"}, req_ready, model_ready(g));
        @(posedge clk);
        model_clock(g);
        #1;
        check({tag, " out_valid"}, out_valid, m_valid);
        if (m_valid) begin
            check({tag, " out_id"}, out_id, m_id);
            check({tag, " out_data"}, out_data, m_data);
            check({tag, " out_last"}, out_last, m_last);
        end
        check({tag, " locked"}, locked, m_locked);
    endtask

    initial begin
        int xg;
        logic [3:0] pend, plast;

        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[5]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[6]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[7]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};
        tbl[9]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0};
        tbl[10] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[11] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[12] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};

        for (int i = 0; i < N; i++) dat[i] = 32'hC0DE_0000 + i;

        // Reset with every requester valid
        rst_n = 1'b0; req_valid = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
        model_reset();
        @(negedge clk); @(negedge clk); #1;
        check("rst req_ready", req_ready, 4'b0000);
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_id", out_id, 2'd0);
        check("rst out_data", out_data, 32'd0);
        check("rst locked", locked, 1'b0);
        @(negedge clk);
        req_valid = 4'b0000;
        rst_n = 1'b1;

        // Vector table: rotation, sparse, empty, stall
        for (int i = 0; i < 14; i++) begin
            int g;
            drive(tbl[i].v, 4'b1111, tbl[i].r);
            #1;
            g = model_grant(req_valid);
            check($sformatf("tbl%0d req_ready", i), req_ready, tbl[i].rdy);
            @(posedge clk);
            model_clock(g);
            #1;
            check($sformatf("tbl%0d out_valid", i), out_valid, tbl[i].ov);
            check($sformatf("tbl%0d out_id", i), out_id, tbl[i].id);
            if (tbl[i].ov)
                check($sformatf("tbl%0d out_data", i), out_data, 32'hC0DE_0000 + tbl[i].id);
        end

        // Backpressure: beat 0xA5 from requester 2 held for 3 cycles
        dat[2] = 32'h0000_00A5;
        dat[3] = 32'h0000_0033;
        drive(4'b0100, 4'b1111, 1'b0);
        step_model("bp load", xg);
        check("bp load id", out_id, 2'd2);
        for (int c = 0; c < 3; c++) begin
            drive(4'b1000, 4'b1111, 1'b0);
            step_model($sformatf("bp stall%0d", c), xg);
            check($sformatf("bp stall%0d data", c), out_data, 32'h0000_00A5);
        end
        drive(4'b1000, 4'b1111, 1'b1);
        step_model("bp release", xg);
        check("bp next id", out_id, 2'd3);
        check("bp next data", out_data, 32'h0000_0033);
        drive(4'b0000, 4'b1111, 1'b1);
        step_model("bp drain", xg);
        check("bp drained", out_valid, 1'b0);

        // Random traffic obeying the hold-until-ready rule
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0;
        #1;
        check("rnd rst out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        pend = '0; plast = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]  = 1'b1;
                    dat[i]   = $urandom;
                    plast[i] = ($urandom_range(0, 3) != 0);
                end
            end
            drive(pend, plast, $urandom_range(0, 3) != 0);
            step_model($sformatf("rnd%0d", c), xg);
            if (xg >= 0) pend[xg] = 1'b0;
        end

`ifdef PIPE_RR_ARBITER_LOCK_EN
        // 3-beat burst from requester 0 while requester 1 waits
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) dat[i] = 32'hB000_0000 + i;
        drive(4'b0011, 4'b0010, 1'b1);
        step_model("lock b1", xg);
        check("lock b1 id", out_id, 2'd0);
        check("lock b1 locked", locked, 1'b1);
        drive(4'b0011, 4'b0010, 1'b1);
        step_model("lock b2", xg);
        check("lock b2 id", out_id, 2'd0);
        check("lock b2 locked", locked, 1'b1);
        drive(4'b0011, 4'b0011, 1'b1);
        step_model("lock b3", xg);
        check("lock b3 id", out_id, 2'd0);
        check("lock b3 locked", locked, 1'b0);
        drive(4'b0010, 4'b0010, 1'b1);
        step_model("lock after", xg);
        check("lock after id", out_id, 2'd1);

        // Reset after the first beat of a burst
        drive(4'b0011, 4'b0010, 1'b1);
        step_model("midrst b1", xg);
        check("midrst b1 locked", locked, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst locked", locked, 1'b0);
        check("midrst out_valid", out_valid, 1'b0);
        check("midrst req_ready", req_ready, 4'b0000);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        model_reset();
        #1;
        check("midrst no stale", out_valid, 1'b0);
        drive(4'b0011, 4'b0011, 1'b1);
        step_model("midrst regrant", xg);
        check("midrst regrant id", out_id, 2'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
